// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the single-sprite renderer.
// Screen constants describe the 640x480 active area the renderer draws into.
package sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // ROM address width covering every frame stored back-to-back.
  function automatic int sprite_addr_w(input int frames, input int w, input int h);
    return $clog2(frames * w * h);
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Sprite ROM and palette bus between the renderer and its external asset storage.
// No handshake: rom_q is valid a fixed ROM_LAT cycles after rom_addr, and the palette answers pal_idx combinationally.
interface sprite_renderer_if #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 4
);

  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_idx;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_addr,
    output pal_idx,
    input  rom_q,
    input  pal_red,
    input  pal_green,
    input  pal_blue
  );

  modport slave (
    input  rom_addr,
    input  pal_idx,
    output rom_q,
    output pal_red,
    output pal_green,
    output pal_blue
  );

endinterface

// File: rtl/sprite_anim_ctrl.sv
// Animation frame sequencer: steps one frame every ANIM_DIV video frames.
// Only acts on frame_start so the addressed frame never changes mid-frame.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int ANIM_DIV   = 8,
  parameter int FRAME_W    = cnt_w(NUM_FRAMES),
  parameter int DIV_W      = cnt_w(ANIM_DIV)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               frame_start_i,
  input  logic               anim_en_i,
  input  logic               anim_rst_i,
  output logic [FRAME_W-1:0] frame_o
);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;

  always_comb begin
    frame_d = frame_q;
    div_d   = div_q;
    if (frame_start_i) begin
      // anim_rst wins over anim_en.
      if (anim_rst_i) begin
        frame_d = '0;
        div_d   = '0;
      end else if (anim_en_i) begin
        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
          div_d   = '0;
          frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      div_q   <= '0;
    end else begin
      frame_q <= frame_d;
      div_q   <= div_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/sprite_renderer.sv
// Draws one scaled, optionally mirrored, animated palettised sprite over a background colour.
// Pixel colour emerges ROM_LAT+1 cycles after DrawX/DrawY.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SPRITE_W        = 16,
  parameter int SPRITE_H        = 16,
  parameter int SCALE_LOG2      = 1,
  parameter int NUM_FRAMES      = 4,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ANIM_DIV        = 8,
  parameter int ROM_LAT         = 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               flip_h,
  input  logic               anim_en,
  input  logic               anim_rst,
  input  logic [3:0]         bg_red,
  input  logic [3:0]         bg_green,
  input  logic [3:0]         bg_blue,
  sprite_renderer_if.master  mem,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam int ADDR_W  = sprite_addr_w(NUM_FRAMES, SPRITE_W, SPRITE_H);
  localparam int FRAME_W = cnt_w(NUM_FRAMES);
  localparam int COL_W   = cnt_w(SPRITE_W);
  localparam int ROW_W   = cnt_w(SPRITE_H);
  localparam int SPAN_X  = SPRITE_W << SCALE_LOG2;
  localparam int SPAN_Y  = SPRITE_H << SCALE_LOG2;

  // Shadow copies of position and flip, refreshed only at frame boundaries.
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic               flip_q, flip_d;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    flip_d  = flip_q;
    if (frame_start) begin
      pos_x_d = pos_x;
      pos_y_d = pos_y;
      flip_d  = flip_h;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      flip_q  <= 1'b0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      flip_q  <= flip_d;
    end
  end

  logic [FRAME_W-1:0] anim_frame;

  sprite_anim_ctrl #(
    .NUM_FRAMES (NUM_FRAMES),
    .ANIM_DIV   (ANIM_DIV)
  ) u_anim (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .frame_start_i (frame_start),
    .anim_en_i     (anim_en),
    .anim_rst_i    (anim_rst),
    .frame_o       (anim_frame)
  );

  // Local coordinates in 11-bit two's complement; bit 10 set means left of / above the sprite,
  // which also clips sprites hanging off any screen edge without wrap-around.
  logic [10:0]       lx, ly;
  logic              hit;
  logic [COL_W-1:0]  col_raw, col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] rom_addr_c;

  assign lx  = {1'b0, DrawX} - {1'b0, pos_x_q};
  assign ly  = {1'b0, DrawY} - {1'b0, pos_y_q};
  assign hit = !lx[10] && (lx < 11'(SPAN_X)) && !ly[10] && (ly < 11'(SPAN_Y));

  assign col_raw = lx[SCALE_LOG2 +: COL_W];
  assign row     = ly[SCALE_LOG2 +: ROW_W];
  // W is a power of two, so W-1-col is the bitwise complement.
  assign col     = flip_q ? ~col_raw : col_raw;

  // frame*W*H + row*W + col reduces to a concatenation for power-of-two dimensions.
  assign rom_addr_c   = hit ? ADDR_W'({anim_frame, row, col}) : '0;
  assign mem.rom_addr = rom_addr_c;
  assign mem.pal_idx  = mem.rom_q;

  logic [ROM_LAT-1:0] hit_dl_q, hit_dl_d;
  logic [ROM_LAT-1:0] blank_dl_q, blank_dl_d;

  always_comb begin
    hit_dl_d      = hit_dl_q;
    blank_dl_d    = blank_dl_q;
    hit_dl_d[0]   = hit;
    blank_dl_d[0] = blank;
    for (int i = 1; i < ROM_LAT; i++) begin
      hit_dl_d[i]   = hit_dl_q[i-1];
      blank_dl_d[i] = blank_dl_q[i-1];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_dl_q   <= '0;
      blank_dl_q <= '0;
    end else begin
      hit_dl_q   <= hit_dl_d;
      blank_dl_q <= blank_dl_d;
    end
  end

  logic hit_al, blank_al;
  rgb_t pal_rgb, bg_rgb, pix_d, pix_q;

  assign hit_al   = hit_dl_q[ROM_LAT-1];
  assign blank_al = blank_dl_q[ROM_LAT-1];
  assign pal_rgb  = '{r: mem.pal_red, g: mem.pal_green, b: mem.pal_blue};
  assign bg_rgb   = '{r: bg_red, g: bg_green, b: bg_blue};

  always_comb begin
    pix_d = '0;
    if (blank_al) begin
      if (!hit_al || (mem.rom_q == IDX_W'(TRANSPARENT_IDX))) begin
        pix_d = bg_rgb;
      end else begin
        pix_d = pal_rgb;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised scoreboard bench for sprite_renderer against a coordinate-level reference model.
module tb_sprite_renderer;
  import sprite_pkg::*;

  localparam int W = 16, H = 16, SC = 1, NF = 4, IDXW = 4, TIDX = 0, ADIV = 8, LAT = 1;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic       blank = 1'b0, frame_start = 1'b0, flip_h = 1'b0, anim_en = 1'b0, anim_rst = 1'b0;
  logic [3:0] bg_red = 4'hA, bg_green = 4'h5, bg_blue = 4'hC;
  logic [3:0] red, green, blue;

  sprite_renderer_if #(.ADDR_W(AW), .IDX_W(IDXW)) mem ();

  sprite_renderer dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip_h      (flip_h),
    .anim_en     (anim_en),
    .anim_rst    (anim_rst),
    .bg_red      (bg_red),
    .bg_green    (bg_green),
    .bg_blue     (bg_blue),
    .mem         (mem),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  // ---------------- external ROM and palette ----------------
  logic [3:0] rom [0:1023];
  always @(posedge vga_clk) mem.rom_q <= rom[mem.rom_addr];

  function automatic logic [11:0] pal_of(input logic [3:0] i);
    return {i, ~i, i + 4'd7};
  endfunction
  assign {mem.pal_red, mem.pal_green, mem.pal_blue} = pal_of(mem.pal_idx);

  // ---------------- reference model ----------------
  int m_px = 0, m_py = 0, m_steps = 0;
  bit m_flip = 1'b0;

  function automatic int model_addr(input int x, input int y, output bit hit);
    int lx, ly, col, row, frame;
    lx  = x - m_px;
    ly  = y - m_py;
    hit = (lx >= 0) && (lx < W * (1 << SC)) && (ly >= 0) && (ly < H * (1 << SC));
    if (!hit) return 0;
    col = lx / (1 << SC);
    if (m_flip) col = W - 1 - col;
    row   = ly / (1 << SC);
    frame = (m_steps / ADIV) % NF;
    return frame * W * H + row * W + col;
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int          due_q[$];
  int          cyc = 0;
  int          n_cmp = 0, n_fail = 0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge vga_clk) begin
    #1;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check("pixel_rgb", {20'h0, red, green, blue}, {20'h0, e});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pixel(input int x, input int y, input bit b);
    int          a;
    bit          h;
    logic [11:0] e;
    @(negedge vga_clk);
    frame_start = 1'b0;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    a = model_addr(x, y, h);
    if (!b) e = 12'h000;
    else if (!h || rom[a] == 4'(TIDX)) e = {bg_red, bg_green, bg_blue};
    else e = pal_of(rom[a]);
    exp_q.push_back(e);
    due_q.push_back(cyc + LAT + 1);
    #1;
    check("rom_addr", 32'(mem.rom_addr), 32'(a));
  endtask

  task automatic pulse_frame(input bit en, input bit rst);
    @(negedge vga_clk);
    frame_start = 1'b1;
    anim_en  = en;
    anim_rst = rst;
    blank    = 1'b0;
    m_px   = int'(pos_x);
    m_py   = int'(pos_y);
    m_flip = flip_h;
    if (rst) m_steps = 0;
    else if (en) m_steps++;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  task automatic random_pixel();
    int x, y;
    if ($urandom_range(0, 3) != 0) begin
      x = (m_px + $urandom_range(0, 47) - 8) & 1023;
      y = (m_py + $urandom_range(0, 47) - 8) & 1023;
    end else begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
    end
    drive_pixel(x, y, $urandom_range(0, 4) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[17] = 4'd3;
    rom[20] = 4'(TIDX);
    rom[15] = 4'd9;
    rom[0]  = 4'd5;

    repeat (3) @(negedge vga_clk);
    #1 check("reset_rgb", {20'h0, red, green, blue}, 32'h0);
    @(negedge vga_clk);
    reset_n = 1'b1;

    // Directed: hit test, edges, blank, transparency
    pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0;
    pulse_frame(1'b0, 1'b0);
    drive_pixel(102, 53, 1'b1);
    drive_pixel(99, 53, 1'b1);
    drive_pixel(132, 53, 1'b1);
    drive_pixel(131, 53, 1'b1);
    drive_pixel(102, 53, 1'b0);
    drive_pixel(108, 53, 1'b1);
    drive_pixel(100, 81, 1'b1);
    drive_pixel(100, 82, 1'b1);
    drive_pixel(100, 49, 1'b1);

    // Flip only takes effect at frame_start
    flip_h = 1'b1;
    drive_pixel(100, 50, 1'b1);
    pulse_frame(1'b0, 1'b0);
    drive_pixel(100, 50, 1'b1);
    drive_pixel(131, 50, 1'b1);
    flip_h = 1'b0;
    pulse_frame(1'b0, 1'b0);

    // Animation stepping, wrap, reset priority
    for (int i = 0; i < 8; i++) pulse_frame(1'b1, 1'b0);
    drive_pixel(100, 50, 1'b1);
    for (int i = 0; i < 24; i++) pulse_frame(1'b1, 1'b0);
    drive_pixel(100, 50, 1'b1);
    for (int i = 0; i < 11; i++) pulse_frame(1'b1, 1'b0);
    drive_pixel(102, 53, 1'b1);
    pulse_frame(1'b1, 1'b1);
    drive_pixel(102, 53, 1'b1);
    for (int i = 0; i < 7; i++) pulse_frame(1'b1, 1'b0);
    drive_pixel(102, 53, 1'b1);
    pulse_frame(1'b1, 1'b0);
    drive_pixel(102, 53, 1'b1);
    pulse_frame(1'b0, 1'b0);
    drive_pixel(102, 53, 1'b1);

    // Position change without frame_start is ignored until the next one
    pos_x = 10'd300;
    drive_pixel(102, 53, 1'b1);
    drive_pixel(302, 53, 1'b1);
    pulse_frame(1'b0, 1'b0);
    drive_pixel(302, 53, 1'b1);

    // Partially off-screen sprite must clip rather than wrap
    pos_x = 10'd1010; pos_y = 10'd470;
    pulse_frame(1'b0, 1'b0);
    drive_pixel(5, 475, 1'b1);
    drive_pixel(1015, 475, 1'b1);
    drive_pixel(1015, 2, 1'b1);

    // Randomised mix of pixels, frame pulses and mid-frame position writes
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 31);
      if (r == 0) begin
        pos_x = 10'($urandom_range(0, 1023));
        pos_y = 10'($urandom_range(0, 1023));
        flip_h = 1'($urandom_range(0, 1));
        pulse_frame(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) == 0));
      end else if (r == 1) begin
        pos_x = 10'($urandom_range(0, 1023));
        flip_h = ~flip_h;
        random_pixel();
      end else begin
        random_pixel();
      end
    end

    // Mid-line reset: outputs clear at once and animation restarts at frame 0
    pos_x = 10'd0; pos_y = 10'd0; flip_h = 1'b0;
    pulse_frame(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) pulse_frame(1'b1, 1'b0);
    drive_pixel(2, 3, 1'b1);
    drive_pixel(3, 3, 1'b1);
    @(posedge vga_clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_rgb", {20'h0, red, green, blue}, 32'h0);
    exp_q.delete();
    due_q.delete();
    m_px = 0; m_py = 0; m_flip = 1'b0; m_steps = 0;
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    @(posedge vga_clk);
    #1;
    check("refill_black", {20'h0, red, green, blue}, 32'h0);
    drive_pixel(2, 3, 1'b1);
    drive_pixel(0, 0, 1'b1);
    for (int i = 0; i < 60; i++) random_pixel();

    // Drain, with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge vga_clk);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Parametrised single-sprite renderer for the VGA pipeline. It draws one W×H palettised sprite at a programmable screen position, with integer power-of-two scaling and horizontal flip. Index 0 (configurable) is drawn as transparent over a background colour, and the sprite steps through a run of animation frames stored back-to-back in an external ROM. It sits between the VGA controller (DrawX/DrawY/blank) and the DAC outputs, replacing full-screen stretch-only sprite display.

## Interface
- SPRITE_W, 16, sprite width in source pixels (power of two)
- SPRITE_H, 16, sprite height in source pixels (power of two)
- SCALE_LOG2, 1, on-screen scale = 2^SCALE_LOG2 in both axes
- NUM_FRAMES, 4, animation frames stored consecutively in ROM
- IDX_W, 4, palette index width
- TRANSPARENT_IDX, 0, index rendered as background
- ANIM_DIV, 8, video frames per animation step (≥1)
- ROM_LAT, 1, external ROM read latency in vga_clk cycles (≥1)
- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate
- blank  in  1  1 = visible region
- frame_start  in  1  one-cycle pulse at start of each video frame
- pos_x, pos_y  in  10 each  sprite top-left on screen
- flip_h  in  1  mirror sprite horizontally
- anim_en  in  1  advance animation
- anim_rst  in  1  force animation frame 0
- bg_red, bg_green, bg_blue  in  4 each  background colour
- rom_addr  out  ADDR_W  ROM address, ADDR_W = clog2(NUM_FRAMES·SPRITE_W·SPRITE_H)
- rom_q  in  IDX_W  ROM data, valid ROM_LAT cycles after rom_addr
- pal_idx  out  IDX_W  palette index to the external combinational palette
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_idx
- red, green, blue  out  4 each  registered pixel colour

## Operation
- Shadow registers: pos_x/pos_y/flip_h are captured only on frame_start, so there is no tearing mid-frame. Reset value 0.
- Hit test (stage 0, combinational on DrawX/DrawY and shadows):
  - lx = DrawX − pos_x_s, ly = DrawY − pos_y_s, both 11-bit signed.
  - hit = 0 ≤ lx < SPRITE_W<<SCALE_LOG2 and 0 ≤ ly < SPRITE_H<<SCALE_LOG2.
- Address:
  - col = lx>>SCALE_LOG2. If flip_s, col = SPRITE_W−1−col.
  - row = ly>>SCALE_LOG2.
  - rom_addr = anim_frame·W·H + row·W + col.
  - rom_addr is 0 when hit=0.
- Animation controller, evaluated only on frame_start:
  - anim_rst → frame=0, div=0. This has priority over anim_en.
  - else if anim_en: if div==ANIM_DIV−1 then div=0 and frame=(frame+1) mod NUM_FRAMES; else div+1.
  - anim_en low holds both values.
  - The frame value used for addressing changes only on frame_start.
- Delay line: hit and blank are delayed ROM_LAT cycles to align with rom_q. pal_idx = rom_q.
- Output register (cycle ROM_LAT+1):
  - blank_d=0 → colour 0.
  - blank_d=1 and (hit_d=0 or rom_q==TRANSPARENT_IDX) → bg colour.
  - otherwise → pal colour.
- Sprite partially off-screen: the wrap of lx/ly into negative values yields hit=0, so the sprite is clipped with no wrap-around artefacts.

## Timing
- Latency from DrawX/DrawY to red/green/blue is ROM_LAT+1 cycles. The VGA controller delays hsync/vsync to match.
- Reset: red/green/blue=0, shadows=0, anim frame=0, div=0, delay-line contents=0 (blank_d=0, so black output until the pipeline refills).
- frame_start and anim_rst in the same cycle → frame=0, and shadows are captured.
- Reset asserted mid-line: outputs go to 0 immediately (async). Operation resumes ROM_LAT+1 cycles after release.

## Structure
- Package sprite_pkg:
  - rgb_t struct (4-bit r/g/b)
  - clog2-derived ADDR_W helper
  - screen constants H_ACTIVE=640, V_ACTIVE=480
- Sub-module sprite_anim_ctrl holds the div/frame counters and the anim_rst/anim_en priority. It has its own test bench.
- The ROM and palette stay external, so one renderer serves any sprite asset.

## Test plan
- Defaults, pos=(100,50), flip=0, anim frame 0, DrawX=102, DrawY=53 → rom_addr=1·16+1=17. Colour appears 2 cycles later and equals pal colour of rom_q.
- Same position, DrawX=99 or DrawX=132 → hit=0, output = bg colour. With blank=0 the output is 0.
- flip_h=1 captured on frame_start, DrawX=100, DrawY=50 → rom_addr=15.
- rom_q=TRANSPARENT_IDX inside the sprite → bg colour. rom_q=3 → palette[3].
- anim_en=1, ANIM_DIV=8: after 8 frame_start pulses frame=1 (rom_addr base 256). After 32 pulses frame wraps to 0. anim_rst together with a pulse → frame=0, div=0.
- pos_x changed mid-frame without frame_start → addressing unchanged until the next frame_start. Reset pulse mid-line → outputs 0 immediately and frame=0.
